countdown_seg_timer: RTL and testbench

COUNTDOWN_SEG_TIMER -- requirements
Module: countdown_seg_timer

---
 rtl/countdown_seg_timer.sv | 70 +++++++
 tb/tb_countdown_seg_timer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/countdown_seg_timer.sv
// Purpose: one-digit countdown timer with active-low 7-seg decode; optional COUNTDOWN_BLANK_EN blanks seg outside the run state.
// Latency: current_digit/flag registered (one tick every CLK_HZ run cycles); seg is combinational from current_digit.
// Backpressure: none; leaving the run state reloads START_DIGIT and restarts the count.
module countdown_seg_timer #(
    parameter int          CLK_HZ      = 50000000,
    parameter int          START_DIGIT = 9,
    parameter logic [3:0]  RUN_STATE   = 4'b1011
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] state,
    output logic       flag,
    output logic [3:0] current_digit,
    output logic [6:0] seg
);

    // A 1 Hz-per-cycle build still needs a 1-bit prescaler.
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_HZ - 1);
    localparam logic [3:0]    START_VAL = 4'(START_DIGIT);

    logic [PW-1:0] prescaler;
    logic          running;

    assign running = (state == RUN_STATE);

    always_ff @(posedge clk) begin
        if (reset || !running) begin
            prescaler     <= '0;
            current_digit <= START_VAL;
            flag          <= 1'b0;
        end else if (current_digit == 4'd0) begin
            // Terminal: hold zero with the prescaler parked.
            prescaler     <= '0;
            flag          <= 1'b1;
        end else if (prescaler == PRE_LAST) begin
            prescaler     <= '0;
            current_digit <= current_digit - 4'd1;
            flag          <= (current_digit == 4'd1);
        end else begin
            prescaler     <= prescaler + PW'(1);
        end
    end

    logic [6:0] seg_dec;

    always_comb begin
        seg_dec = 7'h7F;
        case (current_digit)
            4'd0: seg_dec = 7'h40;
            4'd1: seg_dec = 7'h79;
            4'd2: seg_dec = 7'h24;
            4'd3: seg_dec = 7'h30;
            4'd4: seg_dec = 7'h19;
            4'd5: seg_dec = 7'h12;
            4'd6: seg_dec = 7'h02;
            4'd7: seg_dec = 7'h78;
            4'd8: seg_dec = 7'h00;
            4'd9: seg_dec = 7'h10;
            default: seg_dec = 7'h7F;
        endcase
    end

`ifdef COUNTDOWN_BLANK_EN
    assign seg = running ? seg_dec : 7'h7F;
`else
    assign seg = seg_dec;
`endif

endmodule

// File: tb/tb_countdown_seg_timer.sv
// Directed bench for countdown_seg_timer with CLK_HZ=4, START_DIGIT=9, RUN_STATE=4'b1011.
module tb_countdown_seg_timer;

    localparam logic [3:0] RUN = 4'b1011;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] state;
    logic       flag;
    logic [3:0] current_digit;
    logic [6:0] seg;

    int compared   = 0;
    int mismatched = 0;

    logic [6:0] seg_tab [0:15];

    countdown_seg_timer #(.CLK_HZ(4), .START_DIGIT(9), .RUN_STATE(RUN)) dut (
        .clk           (clk),
        .reset         (reset),
        .state         (state),
        .flag          (flag),
        .current_digit (current_digit),
        .seg           (seg)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected seg when the display would be idle (not in run state) showing 9.
    function automatic logic [6:0] idle_seg();
`ifdef COUNTDOWN_BLANK_EN
        return 7'h7F;
`else
        return 7'h10;
`endif
    endfunction

    initial begin
        seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
        seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
        seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'h7F;

        // Reset with state idle
        reset = 1'b1;
        state = 4'd0;
        step(2);
        check("rst_digit", 7'(current_digit), 7'd9);
        check("rst_flag",  7'(flag), 7'd0);
        check("rst_seg",   seg, idle_seg());
        reset = 1'b0;

        // Full countdown: digit changes every 4 edges, flag on edge 36
        state = RUN;
        for (int c = 1; c <= 36; c++) begin
            step(1);
            check($sformatf("cnt_digit_c%0d", c), 7'(current_digit), 7'(9 - c / 4));
            check($sformatf("cnt_flag_c%0d", c),  7'(flag), (c == 36) ? 7'd1 : 7'd0);
            check($sformatf("cnt_seg_c%0d", c),   seg, seg_tab[9 - c / 4]);
        end

        // Terminal hold
        for (int c = 1; c <= 10; c++) begin
            step(1);
            check("term_digit", 7'(current_digit), 7'd0);
            check("term_flag",  7'(flag), 7'd1);
        end

        // Leave run state
        state = 4'b1101;
        step(1);
        check("leave_digit", 7'(current_digit), 7'd9);
        check("leave_flag",  7'(flag), 7'd0);
        check("leave_seg",   seg, idle_seg());

        // Mid-count exit and re-entry
        state = RUN;
        step(10);
        check("mid_digit", 7'(current_digit), 7'd7);
        state = 4'b0011;
        step(1);
        check("exit_digit", 7'(current_digit), 7'd9);
        state = RUN;
        step(3);
        check("reentry_hold", 7'(current_digit), 7'd9);
        step(1);
        check("reentry_dec", 7'(current_digit), 7'd8);

        // Reset on edge 18 of a fresh countdown
        state = 4'd0;
        step(1);
        state = RUN;
        step(17);
        check("pre_rst_digit", 7'(current_digit), 7'd5);
        reset = 1'b1;
        step(1);
        check("midrst_digit", 7'(current_digit), 7'd9);
        check("midrst_flag",  7'(flag), 7'd0);
        reset = 1'b0;
        step(3);
        check("midrst_hold", 7'(current_digit), 7'd9);
        step(1);
        check("midrst_dec", 7'(current_digit), 7'd8);

        // Reset priority at terminal while state stays RUN
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(36);
        check("term2_digit", 7'(current_digit), 7'd0);
        check("term2_flag",  7'(flag), 7'd1);
        reset = 1'b1;
        step(1);
        check("termrst_digit", 7'(current_digit), 7'd9);
        check("termrst_flag",  7'(flag), 7'd0);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
